// File: rtl/instr_sequencer_pkg.sv
// Encodings shared by the instruction sequencer and the datapath controller:
// FSM states, instruction field layout and the HALT opcode.
package instr_sequencer_pkg;

  typedef enum logic [6:0] {
    ST_IDLE  = 7'b000_0001,
    ST_FETCH = 7'b000_0010,
    ST_ISSUE = 7'b000_0100,
    ST_ACK   = 7'b000_1000,
    ST_EXEC  = 7'b001_0000,
    ST_DONE  = 7'b010_0000,
    ST_ERR   = 7'b100_0000
  } seq_state_t;

  localparam int         INSTR_W  = 16;
  localparam logic [2:0] OPC_HALT = 3'b111;

  // opcode = [15:13], op = [12:11], remaining bits are operand payload
  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [10:0] arg;
  } instr_t;

  function automatic logic is_halt(input instr_t i);
    return i.opcode == OPC_HALT;
  endfunction

endpackage

// File: rtl/instr_sequencer_mem.sv
// Program store: single synchronous write port, asynchronous (zero-latency) read.
// Not reset, so a reset mid-run keeps the loaded program; the write has no backpressure.
module seq_prog_mem
  import instr_sequencer_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Walks program memory from address 0, handing each instruction to the controller via s/w.
// One FETCH/ISSUE/ACK/EXEC pass per instruction, paced entirely by w; ACK stall bounded by ACK_TIMEOUT.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter  int DEPTH       = 16,
  parameter  int ACK_TIMEOUT = 8,
  localparam int AW          = $clog2(DEPTH),
  localparam int TW          = $clog2(ACK_TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic          w,
  output logic          s,
  output logic [15:0]   instr,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [7:0]    retired
);

  seq_state_t    state;
  logic [TW-1:0] tmo_cnt;
  logic [15:0]   mem_rdata;
  logic          mem_we;

  // Writes are only honoured between runs so the program cannot change under the FSM.
  assign mem_we = prog_we & ~busy;

  seq_prog_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (mem_rdata)
  );

  // s must coincide with the cycle in which w=1 is sampled in ISSUE, so it is decoded
  // from the state register rather than registered a cycle late.
  assign s = (state == ST_ISSUE) && w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      instr   <= '0;
      pc      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      retired <= '0;
      tmo_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state   <= ST_FETCH;
            pc      <= '0;
            retired <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            tmo_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (is_halt(mem_rdata)) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            instr <= mem_rdata;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w) begin
            state   <= ST_ACK;
            tmo_cnt <= '0;
          end
        end
        ST_ACK: begin
          if (!w) begin
            state <= ST_EXEC;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (tmo_cnt == TW'(ACK_TIMEOUT - 1)) begin
              state <= ST_ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        ST_EXEC: begin
          if (w) begin
            if (retired != 8'hFF) retired <= retired + 8'd1;
            // The last word ends the run; pc never wraps back to 0.
            if (pc == AW'(DEPTH - 1)) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              pc    <= pc + AW'(1);
              state <= ST_FETCH;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed + randomized bench for instr_sequencer with a reactive controller model.
module tb_instr_sequencer;
  localparam int DEPTH  = 16;
  localparam int ACK_TO = 8;

  logic        clk = 1'b0;
  logic        reset, start, prog_we, w, s, busy, done, err;
  logic [3:0]  prog_addr, pc;
  logic [15:0] prog_data, instr;
  logic [7:0]  retired;

  int vectors = 0, miscompares = 0;
  int ack_hold = 0, exec_delay = 1;
  int hold_left = 0, low_left = 0;
  int s_cnt = 0, instr_chg = 0;
  logic [15:0] prev_instr = 16'h0000;
  logic [15:0] got_q[$];

  logic [15:0] mem_m [DEPTH];
  logic [15:0] exp_q[$];
  int          exp_ret, exp_pc, exp_chg;
  bit          exp_done, exp_err;
  logic [15:0] exp_instr;

  instr_sequencer #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .w(w), .s(s), .instr(instr), .pc(pc), .busy(busy),
    .done(done), .err(err), .retired(retired)
  );

  initial forever #5 clk = ~clk;

  // Controller: idles with w=1; after accepting s keeps w=1 for ack_hold more cycles,
  // then drops w for exec_delay cycles while "executing", then raises w again.
  initial begin
    w = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        w = 1'b1; hold_left = 0; low_left = 0;
      end else if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) begin w = 1'b0; low_left = exec_delay; end
      end else if (low_left > 0) begin
        low_left--;
        if (low_left == 0) w = 1'b1;
      end else if (s) begin
        hold_left = ack_hold + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (s) begin s_cnt++; got_q.push_back(instr); end
    if (instr !== prev_instr) instr_chg++;
    prev_instr = instr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk($sformatf("%s s", tag), 32'(s), 0);
    chk($sformatf("%s instr", tag), 32'(instr), 0);
    chk($sformatf("%s pc", tag), 32'(pc), 0);
    chk($sformatf("%s busy", tag), 32'(busy), 0);
    chk($sformatf("%s done", tag), 32'(done), 0);
    chk($sformatf("%s err", tag), 32'(err), 0);
    chk($sformatf("%s retired", tag), 32'(retired), 0);
  endtask

  task automatic write_all();
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 4'(a); prog_data = mem_m[a];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Reference: walk the program from 0, stop at HALT, at the last word, or on timeout.
  task automatic model_run(input int hold);
    exp_q.delete(); exp_ret = 0; exp_done = 0; exp_err = 0; exp_chg = 0; exp_pc = DEPTH - 1;
    for (int a = 0; a < DEPTH; a++) begin
      if (mem_m[a][15:13] == 3'b111) begin exp_pc = a; break; end
      exp_q.push_back(mem_m[a]);
      if (mem_m[a] !== exp_instr) exp_chg++;
      exp_instr = mem_m[a];
      if (hold >= ACK_TO) begin exp_pc = a; exp_err = 1; break; end
      exp_ret = (exp_ret < 255) ? exp_ret + 1 : 255;
    end
    if (!exp_err) exp_done = 1;
  endtask

  task automatic do_start(input bit we, input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    s_cnt = 0; instr_chg = 0; got_q.delete();
    start = 1'b1; prog_we = we; prog_addr = a; prog_data = d;
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while ((!(done || err) || busy) && n < 3000) begin
      @(negedge clk); n++;
    end
    chk($sformatf("%s finished", tag), 32'(n < 3000), 1);
  endtask

  task automatic check_run(input string tag);
    chk($sformatf("%s done", tag), 32'(done), 32'(exp_done));
    chk($sformatf("%s err", tag), 32'(err), 32'(exp_err));
    chk($sformatf("%s busy", tag), 32'(busy), 0);
    chk($sformatf("%s pc", tag), 32'(pc), 32'(exp_pc));
    chk($sformatf("%s retired", tag), 32'(retired), 32'(exp_ret));
    chk($sformatf("%s s pulses", tag), 32'(s_cnt), 32'(exp_q.size()));
    chk($sformatf("%s instr", tag), 32'(instr), 32'(exp_instr));
    chk($sformatf("%s instr changes", tag), 32'(instr_chg), 32'(exp_chg));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s issue%0d", tag, i),
          (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD_BEEF, 32'(exp_q[i]));
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    exp_instr = 16'h0000;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;

    // MOV_IMM, ADD, HALT
    for (int a = 0; a < DEPTH; a++) mem_m[a] = 16'($urandom);
    mem_m[0] = 16'hD012; mem_m[1] = 16'hA034; mem_m[2] = 16'hE000;
    write_all();
    ack_hold = 0; exec_delay = 1;
    model_run(0);
    do_start(1'b0, 4'd0, 16'h0);
    wait_end("basic");
    check_run("basic");

    // Random programs, handshake timings below the timeout; first one uses a 5-cycle EXEC
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < DEPTH; a++) begin
        logic [2:0] opc = 3'($urandom_range(0, 6));
        mem_m[a] = {opc, 13'($urandom)};
      end
      if ($urandom_range(0, 1) == 1) mem_m[$urandom_range(1, DEPTH - 1)] = 16'hE000 | 16'($urandom_range(0, 8191));
      exec_delay = (r == 0) ? 5 : $urandom_range(1, 6);
      ack_hold   = $urandom_range(0, ACK_TO - 1);
      write_all();
      model_run(ack_hold);
      do_start(1'b0, 4'd0, 16'h0);
      wait_end($sformatf("rand%0d", r));
      check_run($sformatf("rand%0d", r));
    end

    // Full program, no HALT, ACK held one cycle short of the timeout
    for (int a = 0; a < DEPTH; a++) mem_m[a] = {3'($urandom_range(0, 6)), 13'(a * 97 + 5)};
    write_all();
    ack_hold = ACK_TO - 1; exec_delay = 2;
    model_run(ack_hold);
    do_start(1'b0, 4'd0, 16'h0);
    wait_end("full");
    check_run("full");

    // Handshake timeout, then recovery by start
    ack_hold = ACK_TO; exec_delay = 1;
    model_run(ack_hold);
    do_start(1'b0, 4'd0, 16'h0);
    wait_end("timeout");
    check_run("timeout");
    n = s_cnt;
    repeat (12) @(negedge clk);
    chk("timeout no extra s", 32'(s_cnt), 32'(n));
    chk("timeout err sticky", 32'(err), 1);
    ack_hold = 0;
    model_run(0);
    do_start(1'b0, 4'd0, 16'h0);
    chk("restart err cleared", 32'(err), 0);
    chk("restart busy", 32'(busy), 1);
    wait_end("recover");
    check_run("recover");

    // Reset while the second instruction is in EXEC
    exec_delay = 4; ack_hold = 0;
    do_start(1'b0, 4'd0, 16'h0);
    n = 0;
    while (s_cnt < 2 && n < 500) begin @(posedge clk); n++; end
    chk("second issue seen", 32'(n < 500), 1);
    @(negedge clk);
    @(negedge clk);
    chk("pre-reset busy", 32'(busy), 1);
    chk("pre-reset retired", 32'(retired), 1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrun reset");
    reset = 1'b0;
    exp_instr = 16'h0000;
    exec_delay = 1;
    model_run(0);
    do_start(1'b0, 4'd0, 16'h0);
    wait_end("rerun");
    check_run("rerun");

    // Writes and start while busy are dropped; start+write in the same cycle issues the new word
    mem_m[3] = 16'hE000;
    write_all();
    exec_delay = 3;
    model_run(0);
    do_start(1'b0, 4'd0, 16'h0);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = mem_m[1] ^ 16'h00FF; start = 1'b1;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
    wait_end("we_busy");
    check_run("we_busy");
    mem_m[0] = mem_m[0] ^ 16'h0F0F;
    model_run(0);
    do_start(1'b1, 4'd0, mem_m[0]);
    wait_end("we_start");
    check_run("we_start");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of program memory words (power of two; AW = log2(DEPTH)).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 8, meaning the maximum cycles to wait for the controller to drop w after s.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; begins a run from address 0.
REQ-006 prog_we  input  1  program memory write enable.
REQ-007 prog_addr  input  AW  program memory write address.
REQ-008 prog_data  input  16  program memory write data.
REQ-009 w  input  1  controller-waiting flag from the datapath controller (1 = ready for the next instruction).
REQ-010 s  output  1  start strobe to the controller.
REQ-011 instr  output  16  registered instruction: opcode = [15:13], op = [12:11].
REQ-012 pc  output  AW  address of the current instruction.
REQ-013 busy  output  1  high from start acceptance until DONE or ERR.
REQ-014 done  output  1  sticky; run completed normally.
REQ-015 err  output  1  sticky; handshake timeout.
REQ-016 retired  output  8  count of completed instructions; saturates at 255.

Function
REQ-017 FSM states: IDLE, FETCH, ISSUE, ACK, EXEC, DONE, ERR; one-hot encoding.
REQ-018 IDLE: start=1 -> clear pc, retired, done, err; go to FETCH. Otherwise stay.
REQ-019 FETCH: load instr <= mem[pc]; if mem[pc][15:13] == 3'b111 (HALT), go to DONE and leave instr unchanged; else go to ISSUE.
REQ-020 ISSUE: wait for w=1; s=1 for exactly the one cycle in which w=1 is sampled; next state ACK; clear the timeout counter.
REQ-021 ACK: wait for w=0 (controller has left its wait state) -> EXEC; each cycle with w=1 increments the timeout counter; when the counter reaches ACK_TIMEOUT -> ERR.
REQ-022 EXEC: wait for w=1 (instruction finished) -> increment retired (saturating); if pc == DEPTH-1 go to DONE, else pc <= pc+1 and go to FETCH.
REQ-023 instr SHALL stay stable from FETCH through EXEC exit; the controller samples opcode/op at any point in that window.
REQ-024 s SHALL be 0 in every state except ISSUE; s is never asserted twice for one instruction.
REQ-025 DONE: done=1, busy=0; start=1 restarts exactly as in IDLE.
REQ-026 ERR: err=1, busy=0, s=0; only reset or start leaves ERR (start behaves as in IDLE).
REQ-027 start while busy SHALL be ignored.
REQ-028 prog_we SHALL write mem[prog_addr] on the clock edge only when busy=0; writes while busy are dropped.
REQ-029 prog_we and start in the same cycle (busy=0): the write completes first, and the run fetches the updated word.
REQ-030 pc wrap is not allowed: address DEPTH-1 ends the run (REQ-022).

Reset
REQ-031 On reset: state=IDLE, s=0, instr=16'h0000, pc=0, busy=0, done=0, err=0, retired=0, timeout counter=0.
REQ-032 Reset asserted mid-run SHALL abort immediately; program memory contents SHALL be preserved (the memory is not reset).

Structure
REQ-033 State encodings, the HALT opcode (3'b111) and instruction field positions SHALL live in a shared package/include used by both this block and the controller.
REQ-034 Program memory SHALL be a separate sub-module, seq_prog_mem (single write port, asynchronous read); the FSM, counters and output registers SHALL be in instr_sequencer.

Verification
REQ-035 Load {MOV_IMM 16'hD0xx, ADD 16'hA0xx, HALT 16'hE000}, start, controller model -> two s pulses, retired=2, done=1, pc=2.
REQ-036 Controller model holds w=1 after s for 8 cycles -> err=1, busy=0, s stays 0; a following start clears err.
REQ-037 Full program of 16 non-HALT words -> retired=16, done=1, pc=15, no wrap to 0.
REQ-038 Assert reset in EXEC of the 2nd instruction -> all outputs at reset values next cycle; restart re-executes the same memory contents.
REQ-039 prog_we during busy to address 1 -> mem[1] unchanged; start+prog_we in the same cycle to address 0 -> the new word is issued first.
REQ-040 Controller model delays w=1 by 5 cycles in EXEC -> instr stable throughout, no extra s, retired increments once.
